// File: rtl/meter_display_driver_pkg.sv
// Shared constants for the meter display: conversion widths, converter FSM states
// and active-low 7-segment glyphs ({g,f,e,d,c,b,a}).
package meter_display_driver_pkg;

  localparam int CONV_W     = 14;
  localparam int BCD_W      = 16;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg_v;
    case (digit)
      4'd0:    seg_v = 7'h40;
      4'd1:    seg_v = 7'h79;
      4'd2:    seg_v = 7'h24;
      4'd3:    seg_v = 7'h30;
      4'd4:    seg_v = 7'h19;
      4'd5:    seg_v = 7'h12;
      4'd6:    seg_v = 7'h02;
      4'd7:    seg_v = 7'h78;
      4'd8:    seg_v = 7'h00;
      4'd9:    seg_v = 7'h10;
      default: seg_v = SEG_BLANK;
    endcase
    return seg_v;
  endfunction

endpackage

// File: rtl/meter_display_driver_bin2bcd_seq.sv
// Iterative double-dabble converter: one bit per cycle, digits held until the next LOAD.
module bin2bcd_seq
  import meter_display_driver_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CONV_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  conv_state_e             state_q;
  logic [BCD_W+CONV_W-1:0] sr_q;
  logic [3:0]              bit_cnt_q;
  logic [BCD_W-1:0]        bcd_q;
  logic                    done_q;
  logic [BCD_W-1:0]        adj_d;

  // Nibbles of 5 or more get +3 so the following shift carries into the next decade.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
    assign adj_d[gi*4 +: 4] = (sr_q[CONV_W + gi*4 +: 4] >= 4'd5)
                            ? sr_q[CONV_W + gi*4 +: 4] + 4'd3
                            : sr_q[CONV_W + gi*4 +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sr_q      <= {{BCD_W{1'b0}}, bin};
            bit_cnt_q <= '0;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sr_q      <= {adj_d, sr_q[CONV_W-1:0]} << 1;
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(CONV_W - 1)) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          bcd_q   <= sr_q[BCD_W+CONV_W-1:CONV_W];
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/meter_display_driver.sv
// Multiplexed 4-digit display of the meter's seconds count, with leading-zero blanking
// and low-time / expired blink cues driven from the synchronised 1 Hz tick.
module meter_display_driver
  import meter_display_driver_pkg::*;
#(
  parameter int SCAN_DIV   = 2500,
  parameter int LOW_THRESH = 200,
  parameter int MAX_SHOWN  = 9999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk1HZ,
  input  logic [CONV_W-1:0] timeRemain,
  output logic [3:0]        an,
  output logic [6:0]        seg,
  output logic              convDone
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CONV_W-1:0] clamp_val;
  logic [CONV_W-1:0] shown_q;
  logic              valid_q;
  logic              valid_now;
  logic              conv_start;
  logic              conv_busy;
  logic              conv_done;
  logic [BCD_W-1:0]  bcd;
  logic              sync0_q;
  logic              s1_q;
  logic              blink_q;
  logic [CNT_W-1:0]  scan_cnt_q;
  logic [1:0]        digit_idx_q;
  logic [3:0]        lead_blank;
  logic [3:0]        cur_digit;
  logic              cur_blank;
  logic              blink_blank;
  logic [3:0]        an_q;
  logic [6:0]        seg_q;

  assign clamp_val = (timeRemain > CONV_W'(MAX_SHOWN)) ? CONV_W'(MAX_SHOWN) : timeRemain;

  // The LOAD result counts as valid in the done cycle itself so IDLE does not restart.
  assign valid_now  = valid_q | conv_done;
  assign conv_start = !conv_busy && (!valid_now || (clamp_val != shown_q));

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (clamp_val),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lead
    if (gi == 0) begin : g_units
      assign lead_blank[gi] = 1'b0;
    end else begin : g_upper
      assign lead_blank[gi] = (bcd[BCD_W-1:gi*4] == '0);
    end
  end

  assign cur_digit   = bcd[{digit_idx_q, 2'b00} +: 4];
  assign cur_blank   = lead_blank[digit_idx_q];
  assign blink_blank = (shown_q == '0) ? !s1_q
                                       : ((shown_q < CONV_W'(LOW_THRESH)) && blink_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q     <= 1'b0;
      s1_q        <= 1'b0;
      blink_q     <= 1'b0;
      shown_q     <= '0;
      valid_q     <= 1'b0;
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
    end else begin
      sync0_q <= clk1HZ;
      s1_q    <= sync0_q;
      if (sync0_q && !s1_q) begin
        blink_q <= !blink_q;
      end
      if (conv_start) begin
        shown_q <= clamp_val;
      end
      if (conv_done) begin
        valid_q <= 1'b1;
      end
      if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
        scan_cnt_q  <= '0;
        digit_idx_q <= digit_idx_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + CNT_W'(1);
      end
      an_q  <= valid_now ? ~(4'b0001 << digit_idx_q) : 4'b1111;
      seg_q <= (!valid_now || cur_blank || blink_blank) ? SEG_BLANK : seg_encode(cur_digit);
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign convDone = conv_done;

endmodule

// File: tb/tb_meter_display_driver.sv
// Randomised bench for meter_display_driver against a decimal-arithmetic display model.
module tb_meter_display_driver;

  localparam int SCAN_DIV = 2;
  localparam logic [6:0] FONT_ON [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk1HZ = 1'b0;
  logic [13:0] timeRemain = 14'd1234;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        convDone;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int blink_edges = 0;
  bit lvl = 1'b0;
  int shown = 0;

  meter_display_driver #(
    .SCAN_DIV   (SCAN_DIV),
    .LOW_THRESH (200),
    .MAX_SHOWN  (9999)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk1HZ     (clk1HZ),
    .timeRemain (timeRemain),
    .an         (an),
    .seg        (seg),
    .convDone   (convDone)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  function automatic int clampv(input int t);
    return (t > 9999) ? 9999 : t;
  endfunction

  // Expected segments for display position pos when value v is on show.
  function automatic logic [6:0] ref_seg(input int v, input int pos);
    int p = 1;
    for (int k = 0; k < pos; k++) p *= 10;
    if (pos > 0 && v < p) return 7'h7F;
    if (v == 0 && !lvl) return 7'h7F;
    if (v > 0 && v < 200 && (blink_edges % 2) == 1) return 7'h7F;
    return ~FONT_ON[(v / p) % 10];
  endfunction

  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (convDone) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic set_1hz(input bit b);
    @(negedge clk);
    clk1HZ = b;
    if (b && !lvl) blink_edges++;
    lvl = b;
    repeat (6) @(negedge clk);
  endtask

  task automatic apply_val(input int v, input string tag);
    int n;
    int cnt;
    @(negedge clk);
    timeRemain = 14'(v);
    if (clampv(v) != shown) begin
      wait_done(40, n);
      check({tag, "_lat"}, n, 16);
      shown = clampv(v);
      @(posedge clk); #1;
      check({tag, "_pulse"}, convDone, 0);
    end else begin
      cnt = 0;
      repeat (24) begin
        @(posedge clk); #1;
        if (convDone) cnt++;
      end
      check({tag, "_nodone"}, cnt, 0);
    end
  endtask

  task automatic check_display(input string tag);
    logic [3:0] want_an;
    int k;
    for (int i = 0; i < 4; i++) begin
      want_an = ~(4'b0001 << i);
      k = 0;
      @(negedge clk);
      while (an !== want_an && k < 40) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("%s_an%0d", tag, i), an, want_an);
      check($sformatf("%s_seg%0d", tag, i), seg, ref_seg(shown, i));
    end
  endtask

  initial begin
    int n;
    int c0;
    int c1;
    int r;
    int v;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_done", convDone, 0);

    // 1234 converted straight out of reset
    @(negedge clk);
    rst = 1'b0;
    wait_done(40, n);
    check("t1_lat", n, 16);
    shown = 1234;
    @(posedge clk); #1;
    check("t1_pulse", convDone, 0);
    check_display("t1");

    // Low time: 7, blink follows blinkFlag
    apply_val(7, "t2");
    check_display("t2_off");
    set_1hz(1'b1);
    check_display("t2_b1");
    set_1hz(1'b0);
    check_display("t2_b1lo");
    set_1hz(1'b1);
    check_display("t2_b0");

    // Expired: "   0", blank while s1 low
    apply_val(0, "t3");
    check_display("t3_hi");
    set_1hz(1'b0);
    check_display("t3_lo");

    // Clamp
    apply_val(16383, "t4");
    check_display("t4");
    apply_val(9999, "t4b");
    apply_val(10000, "t4c");
    check_display("t4c");

    // Input change during SHIFT
    @(negedge clk);
    timeRemain = 14'd500;
    c0 = cyc;
    repeat (5) @(posedge clk);
    @(negedge clk);
    timeRemain = 14'd499;
    wait_done(40, n);
    check("t5_lat1", cyc - c0, 16);
    c1 = cyc;
    shown = 500;
    @(posedge clk); #1;
    check("t5_pulse", convDone, 0);
    check_display("t5_500");
    wait_done(40, n);
    check("t5_lat2", (n > 0) ? cyc - c1 : -1, 16);
    shown = 499;
    @(posedge clk); #1;
    check_display("t5_499");

    // Reset mid-conversion
    @(negedge clk);
    timeRemain = 14'd3210;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_an", an, 4'hF);
    check("t6_seg", seg, 7'h7F);
    check("t6_done", convDone, 0);
    shown = 0;
    blink_edges = 0;
    @(negedge clk);
    rst = 1'b0;
    wait_done(40, n);
    check("t6_relat", (n > 0 && n <= 17), 1);
    shown = 3210;
    @(posedge clk); #1;
    check_display("t6");

    // Randomised values across each display regime
    for (int it = 0; it < 10; it++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       v = 0;
        1:       v = $urandom_range(1, 199);
        2:       v = $urandom_range(200, 9999);
        default: v = $urandom_range(10000, 16383);
      endcase
      set_1hz(1'($urandom_range(0, 1)));
      apply_val(v, $sformatf("rnd%0d", it));
      check_display($sformatf("rnd%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
